ula_mul_seq: RTL

- Multi-cycle sequencer that computes an unsigned 32x32 -> 64-bit product by driving the shared ULA instance with a shift-add algorithm.
- Owns the ULA control/operand inputs while busy; the product forms in internal hi/lo registers.
- Sits beside the ULA in the execute stage; stalls the core via busy until the result is ready.

---
 rtl/ula_mul_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/ula_mul_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier that drives a shared ULA with shift-add steps.
// Optional MUL_ZERO_BYPASS_EN: a zero operand goes straight to DONE without using the ULA.
module ula_mul_seq #(
   parameter int unsigned WIDTH    = 32,
   parameter logic [3:0]  OPC_ADD  = 4'b0010,
   parameter logic [3:0]  OPC_IDLE = 4'b0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic [3:0]       ula_op,
   output logic [WIDTH-1:0] ula_a,
   output logic [WIDTH-1:0] ula_b,
   input  logic [WIDTH-1:0] ula_r
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

   logic [1:0]       state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             carry;
   logic             zero_op;

`ifdef MUL_ZERO_BYPASS_EN
   assign zero_op = (mcand == '0) || (mplier == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_comb begin
      ula_op = OPC_IDLE;
      ula_a  = '0;
      ula_b  = '0;
      if (state == ST_ITER) begin
         ula_op = OPC_ADD;
         ula_a  = hi;
         ula_b  = lo[0] ? mcand_r : '0;
      end
   end

   // The ULA has no carry out, so recover it from the operand and sum MSBs.
   assign carry = (ula_a[WIDTH-1] & ula_b[WIDTH-1]) |
                  ((ula_a[WIDTH-1] | ula_b[WIDTH-1]) & ~ula_r[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         mcand_r <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mcand_r <= mcand;
                  hi      <= '0;
                  cnt     <= '0;
                  if (zero_op) begin
                     lo    <= '0;
                     state <= ST_DONE;
                  end else begin
                     lo    <= mplier;
                     state <= ST_ITER;
                  end
               end
            end
            ST_ITER: begin
               {hi, lo} <= {carry, ula_r, lo[WIDTH-1:1]};
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);
   assign prod_hi = hi;
   assign prod_lo = lo;

endmodule
